// File: rtl/vector_logic_sequencer_if.sv
// Shared types and request handshake for the vector logic sequencer.
// Requester drives the master side, the sequencer is the slave.
package vector_logic_pkg;
  localparam logic [1:0] LOGIC_AND = 2'd0;
  localparam logic [1:0] LOGIC_OR  = 2'd1;
  localparam logic [1:0] LOGIC_XOR = 2'd2;

  typedef struct packed {
    logic [1:0] op;
    logic       vm;
    logic [4:0] rsvd;
  } execution_vector_t;
endpackage

interface vector_logic_sequencer_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  import vector_logic_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  execution_vector_t         req_execution_vector;
  logic [REG_ADDR_WIDTH-1:0] req_vd_addr;
  logic [REG_ADDR_WIDTH-1:0] req_vs2_addr;
  logic [REG_ADDR_WIDTH-1:0] req_vs1_addr;
  logic [1:0]                req_lmul;

  modport master (
    output req_valid,
    output req_execution_vector,
    output req_vd_addr,
    output req_vs2_addr,
    output req_vs1_addr,
    output req_lmul,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_execution_vector,
    input  req_vd_addr,
    input  req_vs2_addr,
    input  req_vs1_addr,
    input  req_lmul,
    output req_ready
  );
endinterface

// File: rtl/vector_logic_sequencer.sv
// Expands one vector logic instruction into 1/2/4/8 register micro-ops
// and tracks write-backs through the fixed-latency logic unit.
module vector_logic_sequencer
  import vector_logic_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int UNIT_LATENCY   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  vector_logic_sequencer_if.slave   req,
  output logic [REG_ADDR_WIDTH-1:0] rf_vs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] rf_vs1_addr,
  output execution_vector_t         unit_execution_vector,
  output logic                      rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = REG_ADDR_WIDTH;
  localparam int L  = UNIT_LATENCY;
  localparam logic [L-1:0] LAST_BIT = L'(1) << (L - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic [2:0]        r_last;
  logic [AW-1:0]     r_vd;
  logic [AW-1:0]     r_vs2;
  logic [AW-1:0]     r_vs1;
  execution_vector_t r_ev;
  logic [L-1:0]      r_pv;
  logic [AW-1:0]     r_pa [L];
  logic              w_accept;
  logic              w_issue;
  logic              w_last_pop;

  assign w_last_pop = r_pv[L-1] && ((r_pv & ~LAST_BIT) == '0);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: accept, issue N micro-ops, then drain the token pipe.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req.req_valid) w_next = S_ISSUE;
      S_ISSUE: if (r_cnt == r_last) w_next = S_DRAIN;
      S_DRAIN: if (w_last_pop) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    req.req_ready = (r_state == S_IDLE);
    busy          = (r_state != S_IDLE);
    w_accept      = (r_state == S_IDLE) && req.req_valid;
    w_issue       = (r_state == S_ISSUE);
    done          = (r_state == S_DRAIN) && w_last_pop;
  end

  // Request latch and micro-op counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vd   <= '0;
      r_vs2  <= '0;
      r_vs1  <= '0;
      r_ev   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else if (w_accept) begin
      r_vd   <= req.req_vd_addr;
      r_vs2  <= req.req_vs2_addr;
      r_vs1  <= req.req_vs1_addr;
      r_ev   <= req.req_execution_vector;
      r_cnt  <= '0;
      r_last <= 3'((4'd1 << req.req_lmul) - 4'd1);
    end else if (w_issue) begin
      r_cnt  <= r_cnt + 3'd1;
    end
  end

  // Write-back token pipe; addresses only advance with a valid token
  // so the exit stage keeps the last written address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
      for (int k = 0; k < L; k++) r_pa[k] <= '0;
    end else begin
      r_pv <= (r_pv << 1) | L'(w_issue);
      if (w_issue) r_pa[0] <= r_vd + AW'(r_cnt);
      for (int k = 1; k < L; k++) begin
        if (r_pv[k-1]) r_pa[k] <= r_pa[k-1];
      end
    end
  end

  assign rf_vs2_addr           = r_vs2 + AW'(r_cnt);
  assign rf_vs1_addr           = r_vs1 + AW'(r_cnt);
  assign unit_execution_vector = r_ev;
  assign rf_write_en           = r_pv[L-1];
  assign rf_write_addr         = r_pa[L-1];

endmodule
